// File: rtl/player_input_ctrl_if.sv
// rtl/player_input_ctrl_if.sv - key/move bundle between board buttons and the player_input producer
interface player_input_ctrl_if;
  logic [3:0] key_raw;
  logic       gameover;
  logic [3:0] player_input;
  logic [3:0] key_held;

  modport master (
    output key_raw,
    output gameover,
    input  player_input,
    input  key_held
  );

  modport slave (
    input  key_raw,
    input  gameover,
    output player_input,
    output key_held
  );
endinterface

// File: rtl/player_input_ctrl.sv
// rtl/player_input_ctrl.sv - push-button conditioner producing one-hot move pulses with auto-repeat
module player_input_ctrl #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 8,
  parameter int CNT_W           = 16
) (
  input logic                 clk,
  input logic                 reset,
  player_input_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_HELD   = 2'd3;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0] key_pressed;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb;
  logic [3:0] req;
  logic [3:0] grant;

  // Internally 1 always means pressed, whatever the board polarity.
  assign key_pressed = (ACTIVE_LOW != 0) ? ~bus.key_raw : bus.key_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= key_pressed;
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_key
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_k;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] rpt_cnt;
    logic [CNT_W-1:0] rpt_nxt;
    logic             req_k;

    // Any synced sample that agrees with the current level restarts the count.
    always_ff @(posedge clk) begin
      if (reset) begin
        deb_cnt <= '0;
        deb_k   <= 1'b0;
      end else if (sync2[k] == deb_k) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_k   <= sync2[k];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_ONE;
      end
    end

    // Release is checked first so it overrides a repeat falling on the same cycle.
    always_comb begin
      req_k     = 1'b0;
      state_nxt = state;
      rpt_nxt   = rpt_cnt;
      if (!deb_k) begin
        state_nxt = ST_IDLE;
        rpt_nxt   = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            req_k     = 1'b1;
            rpt_nxt   = '0;
            state_nxt = (REPEAT_DELAY == 0) ? ST_HELD : ST_DELAY;
          end
          ST_DELAY: begin
            if (rpt_cnt == DELAY_LAST) begin
              req_k     = 1'b1;
              rpt_nxt   = '0;
              state_nxt = ST_REPEAT;
            end else begin
              rpt_nxt = rpt_cnt + CNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt == RATE_LAST) begin
              req_k   = 1'b1;
              rpt_nxt = '0;
            end else begin
              rpt_nxt = rpt_cnt + CNT_ONE;
            end
          end
          ST_HELD: begin
            req_k = 1'b0;
          end
          default: begin
            state_nxt = ST_IDLE;
            rpt_nxt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= ST_IDLE;
        rpt_cnt <= '0;
      end else begin
        state   <= state_nxt;
        rpt_cnt <= rpt_nxt;
      end
    end

    assign deb[k] = deb_k;
    assign req[k] = req_k;
  end

  // Losing requests are dropped rather than queued.
  always_comb begin
    grant = 4'b0000;
    if (req[3])      grant = 4'b1000;
    else if (req[2]) grant = 4'b0100;
    else if (req[1]) grant = 4'b0010;
    else if (req[0]) grant = 4'b0001;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.player_input <= 4'b0000;
    end else begin
      bus.player_input <= bus.gameover ? 4'b0000 : grant;
    end
  end

  assign bus.key_held = deb;

endmodule

// File: tb/tb_player_input_ctrl.sv
// tb/tb_player_input_ctrl.sv - directed self-checking bench for player_input_ctrl
module tb_player_input_ctrl;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  player_input_ctrl_if bus ();

  player_input_ctrl #(
    .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_RATE(8), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @+%0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.key_raw = 4'hF;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [3:0] exp_po;
    logic [3:0] exp_kh;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.key_raw  = 4'hF;
    bus.gameover = 1'b0;

    // reset state
    for (int i = 1; i <= 2; i++) begin
      tick();
      check("rst_po", i, bus.player_input, 4'b0000);
      check("rst_kh", i, bus.key_held, 4'b0000);
    end
    reset = 1'b0;
    idle(3);

    // single right press, 20 cycles
    bus.key_raw = 4'b1110;
    for (int i = 1; i <= 35; i++) begin
      tick();
      if (i == 20) bus.key_raw = 4'hF;
      exp_po = (i == 7 || i == 23) ? 4'b0001 : 4'b0000;
      exp_kh = (i >= 6 && i <= 25) ? 4'b0001 : 4'b0000;
      check("right_po", i, bus.player_input, exp_po);
      check("right_kh", i, bus.key_held, exp_kh);
    end
    idle(4);

    // bouncing up key never qualifies
    for (int i = 1; i <= 20; i++) begin
      bus.key_raw = (i <= 12 && ((i - 1) % 4) < 2) ? 4'b0111 : 4'hF;
      tick();
      check("bounce_po", i, bus.player_input, 4'b0000);
      check("bounce_kh", i, bus.key_held, 4'b0000);
    end
    idle(4);

    // down held 60 cycles: press then repeats every 8 after the 16-cycle delay
    bus.key_raw = 4'b1011;
    for (int i = 1; i <= 75; i++) begin
      tick();
      if (i == 60) bus.key_raw = 4'hF;
      exp_po = (i == 7 || (i >= 23 && i <= 63 && ((i - 23) % 8) == 0)) ? 4'b0100 : 4'b0000;
      exp_kh = (i >= 6 && i <= 65) ? 4'b0100 : 4'b0000;
      check("down_po", i, bus.player_input, exp_po);
      check("down_kh", i, bus.key_held, exp_kh);
    end
    idle(4);

    // up and left together: up wins the press, left repeats survive once up releases
    bus.key_raw = 4'b0101;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 10) bus.key_raw = 4'b1101;
      if (i == 34) bus.key_raw = 4'hF;
      if (i == 7) exp_po = 4'b1000;
      else if (i == 23 || i == 31 || i == 39) exp_po = 4'b0010;
      else exp_po = 4'b0000;
      exp_kh = {(i >= 6 && i <= 15), 1'b0, (i >= 6 && i <= 39), 1'b0};
      check("prio_po", i, bus.player_input, exp_po);
      check("prio_kh", i, bus.key_held, exp_kh);
    end
    idle(4);

    // gameover masks the press, repeats resume once cleared; reset mid-hold re-presses
    bus.gameover = 1'b1;
    bus.key_raw  = 4'b1110;
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (i == 10) bus.gameover = 1'b0;
      exp_po = (i == 23 || i == 31) ? 4'b0001 : 4'b0000;
      exp_kh = (i >= 6) ? 4'b0001 : 4'b0000;
      check("gover_po", i, bus.player_input, exp_po);
      check("gover_kh", i, bus.key_held, exp_kh);
    end
    reset = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      check("midrst_po", i, bus.player_input, 4'b0000);
      check("midrst_kh", i, bus.key_held, 4'b0000);
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_po = (i == 7) ? 4'b0001 : 4'b0000;
      exp_kh = (i >= 6) ? 4'b0001 : 4'b0000;
      check("repress_po", i, bus.player_input, exp_po);
      check("repress_kh", i, bus.key_held, exp_kh);
    end
    idle(10);
    check("final_kh", 0, bus.key_held, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
